alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Issues operations to the 4-bit ALU and collects its results. Accepts one instruction per valid/ready handshake, drives the ALU opcode and operand buses from registers, waits a fixed settle window, then captures the ALU's selected result. It presents that result on a valid/ready output port and keeps it in an accumulator, so a later instruction can chain on it. It is the issuing end of the ALU's opcode/result interface.

## Interface
- SETTLE_CYCLES, 1: cycles opcode/operands are held stable before the result is captured (≥1).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  12  [11] use_acc, [10:8] opcode, [7:4] operand A, [3:0] operand B.
- opcode  out  3  opcode to the ALU result mux.
- op_a  out  4  operand A to the ALU units.
- op_b  out  4  operand B to the ALU units.
- alu_result  in  4  ALU final result (combinational from opcode/op_a/op_b).
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  4  captured result.
- res_err  out  1  result belongs to a rejected opcode.
- acc  out  4  accumulator (last good result).

## Operation
- Opcode map: 0 suma, 1 complemento, 2 shift right, 3 shift left, 4 compc, 5 compn, 6 reserved, 7 load.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - instr_ready=1.
  - On instr_valid, register opcode and op_b.
  - op_a = acc if use_acc=1, else instr[7:4].
  - Opcode 6 goes directly to HOLD with res_data=0 and res_err=1. The ALU buses are not updated and acc is unchanged.
  - Any other opcode goes to ISSUE and loads the settle counter with SETTLE_CYCLES-1.
- ISSUE:
  - instr_ready=0. opcode/op_a/op_b are held constant.
  - The counter decrements each cycle.
  - On the cycle the counter is 0: res_data and acc take alu_result, res_err=0, next state HOLD.
- HOLD:
  - res_valid=1. res_data, res_err and the ALU buses are stable.
  - When res_ready=1, the next state is IDLE.
  - instr_ready=0, so there is no overlap: a new instruction is accepted no earlier than the cycle after the result handshake.
- After a result, opcode/op_a/op_b keep their last values. The ALU buses only change on an accepted instruction.
- Widths: all data is 4-bit. No carry is kept; alu_result is taken as-is.

## Timing
- Reset values: state IDLE, instr_ready=1, opcode=0, op_a=0, op_b=0, res_valid=0, res_data=0, res_err=0, acc=0, counter=0.
- Latency from instruction accept (edge N) to the edge where the result is captured: SETTLE_CYCLES edges (default: capture at N+1). res_valid is high in the cycle after capture.
- Rejected opcode 6: res_valid is high in the cycle after accept.
- Throughput:
  - One instruction per SETTLE_CYCLES+2 cycles when res_ready is held high.
  - Reserved opcodes: one per 2 cycles.
- res_ready held low: the sequencer stalls in HOLD indefinitely. All outputs stay frozen.
- res_ready high while not in HOLD: ignored.
- instr_valid while instr_ready=0: ignored. The upstream must hold the instruction.
- rst in any state returns to the reset values on the next edge. Any pending result is dropped, and no res_valid pulse is emitted for it.
- use_acc=1 right after reset: op_a=0.

## Test plan
- Reset, then instr={0,3'h0,4'h3,4'h5}, bench ALU model returns 8 -> res_valid one cycle after capture, res_data=8, res_err=0, acc=8.
- After the previous test, instr={1,3'h0,4'hX,4'h2}, model sum -> op_a=8, res_data=4'hA, acc=4'hA.
- instr opcode=6 -> no ALU bus change, res_valid next cycle, res_err=1, res_data=0, acc unchanged.
- res_ready held low 10 cycles in HOLD, instr_valid asserted throughout -> instr_ready=0, res_data stable, no second accept. Release res_ready -> IDLE, then accept.
- SETTLE_CYCLES=3, opcode 3 (shift left) on A=4'b0011 -> buses stable 3 cycles, captured 4'b0110.
- rst asserted in ISSUE -> next cycle all reset values, res_valid never pulses for the dropped instruction.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Instruction, ALU bus and result port bundle between the sequencer and its environment.
// The sequencer takes the master side because it drives the ALU opcode/operand buses.
interface alu_op_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;
  logic [2:0]  opcode;
  logic [3:0]  op_a;
  logic [3:0]  op_b;
  logic [3:0]  alu_result;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_data;
  logic        res_err;
  logic [3:0]  acc;

  modport master (
    input  instr_valid, instr, alu_result, res_ready,
    output instr_ready, opcode, op_a, op_b, res_valid, res_data, res_err, acc
  );

  modport slave (
    output instr_valid, instr, alu_result, res_ready,
    input  instr_ready, opcode, op_a, op_b, res_valid, res_data, res_err, acc
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one instruction at a time to the 4-bit ALU, waits a settle window,
// captures the result into an accumulator and offers it on a valid/ready port.
//
// state | meaning
// IDLE  | ready for an instruction, ALU buses hold their last values
// ISSUE | buses driven and stable, settle counter running down
// HOLD  | result offered on res_valid until res_ready
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  alu_op_sequencer_if.master bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0] OP_RESERVED = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          instr_ready;
  logic [2:0]    opcode;
  logic [3:0]    op_a;
  logic [3:0]    op_b;
  logic          res_valid;
  logic [3:0]    res_data;
  logic          res_err;
  logic [3:0]    acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      instr_ready <= 1'b1;
      opcode      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
      acc         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            instr_ready <= 1'b0;
            // A rejected opcode never reaches the ALU: buses and acc stay put.
            if (bus.instr[10:8] == OP_RESERVED) begin
              res_data  <= '0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              opcode <= bus.instr[10:8];
              op_a   <= bus.instr[11] ? acc : bus.instr[7:4];
              op_b   <= bus.instr[3:0];
              cnt    <= CNT_LOAD;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cnt == '0) begin
            res_data  <= bus.alu_result;
            acc       <= bus.alu_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          instr_ready <= 1'b1;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.opcode      = opcode;
  assign bus.op_a        = op_a;
  assign bus.op_b        = op_b;
  assign bus.res_valid   = res_valid;
  assign bus.res_data    = res_data;
  assign bus.res_err     = res_err;
  assign bus.acc         = acc;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and 3) with a behavioural ALU,
// directed cases followed by random instructions checked against a per-instance model.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_sequencer_if if0 ();
  alu_op_sequencer_if if1 ();

  alu_op_sequencer #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  alu_op_sequencer #(.SETTLE_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int          sel;
  logic        tb_valid;
  logic        tb_rr;
  logic [11:0] tb_instr;

  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return ~a;
      3'd2:    return a >> 1;
      3'd3:    return a << 1;
      3'd4:    return {3'b000, a > b};
      3'd5:    return {3'b000, a == b};
      3'd7:    return b;
      default: return 4'hF;
    endcase
  endfunction

  assign if0.alu_result  = alu_f(if0.opcode, if0.op_a, if0.op_b);
  assign if1.alu_result  = alu_f(if1.opcode, if1.op_a, if1.op_b);
  assign if0.instr_valid = tb_valid && (sel == 0);
  assign if1.instr_valid = tb_valid && (sel == 1);
  assign if0.res_ready   = tb_rr && (sel == 0);
  assign if1.res_ready   = tb_rr && (sel == 1);
  assign if0.instr       = tb_instr;
  assign if1.instr       = tb_instr;

  logic       o_instr_ready, o_res_valid, o_res_err;
  logic [2:0] o_opcode;
  logic [3:0] o_op_a, o_op_b, o_res_data, o_acc;
  assign o_instr_ready = sel ? if1.instr_ready : if0.instr_ready;
  assign o_res_valid   = sel ? if1.res_valid   : if0.res_valid;
  assign o_res_err     = sel ? if1.res_err     : if0.res_err;
  assign o_opcode      = sel ? if1.opcode      : if0.opcode;
  assign o_op_a        = sel ? if1.op_a        : if0.op_a;
  assign o_op_b        = sel ? if1.op_b        : if0.op_b;
  assign o_res_data    = sel ? if1.res_data    : if0.res_data;
  assign o_acc         = sel ? if1.acc         : if0.acc;

  // reference model state per instance
  logic [3:0] m_acc [2];
  logic [2:0] m_op  [2];
  logic [3:0] m_a   [2];
  logic [3:0] m_b   [2];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = '0; m_op[i] = '0; m_a[i] = '0; m_b[i] = '0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, o_instr_ready, 1);
    chk({tag, "_valid"}, o_res_valid, 0);
    chk({tag, "_data"},  o_res_data, 0);
    chk({tag, "_err"},   o_res_err, 0);
    chk({tag, "_acc"},   o_acc, 0);
    chk({tag, "_buses"}, {o_opcode, o_op_a, o_op_b}, 0);
  endtask

  // Runs one instruction through the selected instance; entered and left at a negedge.
  task automatic run_instr(input logic [11:0] ins, input int stall);
    int         s = sel;
    int         settle = sel ? 3 : 1;
    logic [2:0] op = ins[10:8];
    logic [3:0] a = ins[11] ? m_acc[s] : ins[7:4];
    logic       reserved = (op == 3'd6);
    logic [3:0] exp_res;
    int         cnt;
    if (reserved) begin
      exp_res = 4'h0;
    end else begin
      exp_res  = alu_f(op, a, ins[3:0]);
      m_op[s]  = op;
      m_a[s]   = a;
      m_b[s]   = ins[3:0];
      m_acc[s] = exp_res;
    end
    chk("idle_ready", o_instr_ready, 1);
    tb_instr = ins; tb_valid = 1'b1; tb_rr = 1'b0;
    @(posedge clk); @(negedge clk);
    cnt = 0;
    while (o_res_valid !== 1'b1 && cnt < 40) begin
      chk("issue_ready", o_instr_ready, 0);
      chk("issue_buses", {o_opcode, o_op_a, o_op_b}, {m_op[s], m_a[s], m_b[s]});
      @(posedge clk); @(negedge clk);
      cnt++;
    end
    chk("latency", cnt, reserved ? 0 : settle);
    chk("res_valid", o_res_valid, 1);
    chk("res_data", o_res_data, exp_res);
    chk("res_err", o_res_err, reserved);
    chk("acc", o_acc, m_acc[s]);
    chk("hold_buses", {o_opcode, o_op_a, o_op_b}, {m_op[s], m_a[s], m_b[s]});
    chk("hold_ready", o_instr_ready, 0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); @(negedge clk);
      chk("stall_valid", o_res_valid, 1);
      chk("stall_data", o_res_data, exp_res);
      chk("stall_ready", o_instr_ready, 0);
    end
    tb_rr = 1'b1; tb_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    tb_rr = 1'b0;
    chk("post_valid", o_res_valid, 0);
    chk("post_ready", o_instr_ready, 1);
    chk("post_buses", {o_opcode, o_op_a, o_op_b}, {m_op[s], m_a[s], m_b[s]});
    chk("post_acc", o_acc, m_acc[s]);
  endtask

  initial begin
    sel = 0; tb_valid = 1'b0; tb_rr = 1'b0; tb_instr = '0; rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst0");
    sel = 1;
    chk_reset_vals("rst1");

    // settle 1: sum, chained sum, reserved, long stall with valid held
    sel = 0;
    run_instr({1'b0, 3'h0, 4'h3, 4'h5}, 0);
    run_instr({1'b1, 3'h0, 4'($urandom), 4'h2}, 0);
    chk("chain_acc", o_acc, 4'hA);
    run_instr({1'b0, 3'h6, 4'h9, 4'h9}, 1);
    chk("rsv_acc", o_acc, 4'hA);
    run_instr({1'b0, 3'h7, 4'h1, 4'hC}, 10);

    // settle 3: shift left of 0011
    sel = 1;
    run_instr({1'b0, 3'h3, 4'b0011, 4'h7}, 2);
    chk("shl_data", o_res_data, 4'b0110);

    // reset while in ISSUE drops the pending result
    tb_instr = {1'b0, 3'h0, 4'h5, 4'h6}; tb_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    tb_valid = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_reset_vals("rst_issue");
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      chk("no_pulse", o_res_valid, 0);
    end

    // use_acc straight after reset sees op_a = 0
    sel = 0;
    run_instr({1'b1, 3'h0, 4'hB, 4'h3}, 0);
    chk("acc_after_rst_opa", o_op_a, 4'h0);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 1));
      run_instr(12'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
